// File: rtl/simon_round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : simon_round_sequencer_if
// Purpose  : Request, key-store, round-function and result bundle for the
//            Simon32/64 round sequencer.
// Revision : 1.0
// ============================================================================
interface simon_round_sequencer_if #(
    parameter int WORD   = 16,
    parameter int ROUNDS = 32,
    parameter int KIDX_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_decrypt;
    logic [WORD-1:0]   req_x;
    logic [WORD-1:0]   req_y;
    logic [ROUNDS-1:0] key_ready;
    logic [KIDX_W-1:0] key_idx;
    logic [WORD-1:0]   rnd_x;
    logic [WORD-1:0]   rnd_y;
    logic [WORD-1:0]   rnd_x_nxt;
    logic [WORD-1:0]   rnd_y_nxt;
    logic              res_valid;
    logic              res_ready;
    logic [WORD-1:0]   res_x;
    logic [WORD-1:0]   res_y;
    logic              res_decrypt;
    logic              busy;

    modport master (
        output req_valid, req_decrypt, req_x, req_y, key_ready,
               rnd_x_nxt, rnd_y_nxt, res_ready,
        input  req_ready, key_idx, rnd_x, rnd_y, res_valid,
               res_x, res_y, res_decrypt, busy
    );

    modport slave (
        input  req_valid, req_decrypt, req_x, req_y, key_ready,
               rnd_x_nxt, rnd_y_nxt, res_ready,
        output req_ready, key_idx, rnd_x, rnd_y, res_valid,
               res_x, res_y, res_decrypt, busy
    );
endinterface
`default_nettype wire

// File: rtl/simon_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : simon_round_sequencer
// Purpose  : Drives 32 Simon32/64 rounds per block (encrypt/decrypt); optional
//            abort input enabled by macro SEQ_ABORT_EN.
// Revision : 1.0
// ============================================================================
module simon_round_sequencer #(
    parameter int WORD   = 16,
    parameter int ROUNDS = 32,
    parameter int KIDX_W = 5
) (
    input  wire logic clk,
    input  wire logic rst,
`ifdef SEQ_ABORT_EN
    input  wire logic abort,
`endif
    simon_round_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [KIDX_W:0] C_LAST = (KIDX_W+1)'(ROUNDS - 1);

    state_t            state_q, state_d;
    logic [WORD-1:0]   x_q, x_d, y_q, y_d;
    logic [WORD-1:0]   res_x_q, res_x_d, res_y_q, res_y_d;
    logic [KIDX_W:0]   round_q, round_d;
    logic              dec_q, dec_d;
    logic              res_valid_q, res_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic [KIDX_W-1:0] w_kidx;
    logic              w_step;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        round_d     = round_q;
        dec_d       = dec_q;
        res_valid_d = res_valid_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        // Decryption walks the key schedule backwards on the same round function.
        w_kidx      = dec_q ? KIDX_W'(C_LAST - round_q) : round_q[KIDX_W-1:0];
        w_step      = (state_q == S_RUN) && bus.key_ready[w_kidx];

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    x_d         = bus.req_decrypt ? bus.req_y : bus.req_x;
                    y_d         = bus.req_decrypt ? bus.req_x : bus.req_y;
                    dec_d       = bus.req_decrypt;
                    round_d     = '0;
                    state_d     = S_RUN;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_RUN: begin
                if (w_step) begin
                    x_d     = bus.rnd_x_nxt;
                    y_d     = bus.rnd_y_nxt;
                    round_d = round_q + 1'b1;
                    if (round_q == C_LAST) begin
                        res_x_d     = dec_q ? bus.rnd_y_nxt : bus.rnd_x_nxt;
                        res_y_d     = dec_q ? bus.rnd_x_nxt : bus.rnd_y_nxt;
                        res_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                res_valid_d = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase

`ifdef SEQ_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            res_x_d     = res_x_q;
            res_y_d     = res_y_q;
            res_valid_d = 1'b0;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
            round_q     <= '0;
            dec_q       <= 1'b0;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_x_q     <= res_x_d;
            res_y_q     <= res_y_d;
            round_q     <= round_d;
            dec_q       <= dec_d;
            res_valid_q <= res_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.key_idx     = w_kidx;
    assign bus.rnd_x       = x_q;
    assign bus.rnd_y       = y_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_x       = res_x_q;
    assign bus.res_y       = res_y_q;
    assign bus.res_decrypt = dec_q;
    assign bus.busy        = busy_q;
endmodule
`default_nettype wire
